// File: rtl/audio_dac_pkg.sv
// audio_dac_pkg: shared defaults and types for the audio DAC serial path
package audio_dac_pkg;
  localparam int SAMPLE_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, WAIT_L, SHIFT, PAD} state_t;
  typedef struct packed {
    logic [SAMPLE_W_DEF-1:0] left;
    logic [SAMPLE_W_DEF-1:0] right;
  } frame_t;
endpackage

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: synchronous fall-through FIFO holding stereo frames
module audio_sample_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign dout = mem[rd_ptr];
  // pointers and occupancy; a simultaneous push and pop leaves the level unchanged
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  // frame storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/audio_dac_scheduler.sv
// audio_dac_scheduler: buffers stereo frames and serialises them onto the codec DAC line
module audio_dac_scheduler
  import audio_dac_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int I2S_MODE = 1,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic                  enable,
  input  logic [2*SAMPLE_W-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  dac_bclk,
  input  logic                  dac_lrck,
  output logic                  dac_dat,
  output logic [LW-1:0]         fifo_level,
  output logic                  underrun,
  output logic [15:0]           underrun_cnt
);
  localparam int CW = $clog2(SAMPLE_W + 1);
  localparam logic SKIP0 = I2S_MODE != 0;
  logic [2:0] bclk_s, lrck_s;
  logic bfall, lr_edge, lr_new;
  state_t state, n_state;
  logic [SAMPLE_W-1:0] sh, n_sh, hold_r, n_hold;
  logic [CW-1:0] cnt, n_cnt;
  logic skip, n_skip, n_dat, n_und, pop, empty, full;
  logic [15:0] n_ucnt;
  logic [2*SAMPLE_W-1:0] rd;
  assign s_ready = !full;
  assign bfall = bclk_s[2] && !bclk_s[1];
  assign lr_edge = lrck_s[2] ^ lrck_s[1];
  assign lr_new = lrck_s[1];
  audio_sample_fifo #(.W(2*SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_clk),
    .rst(reset_reset),
    .push(s_valid && s_ready),
    .pop(pop),
    .din(s_data),
    .dout(rd),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  // two-flop synchronisers plus a third flop for edge detection
  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) begin
      bclk_s <= '0;
      lrck_s <= '0;
    end else begin
      bclk_s <= {bclk_s[1:0], dac_bclk};
      lrck_s <= {lrck_s[1:0], dac_lrck};
    end
  // load on LRCK edges first, then let a same-cycle bit-clock fall act on the new word
  always_comb begin
    n_state = state;
    n_sh = sh;
    n_hold = hold_r;
    n_cnt = cnt;
    n_skip = skip;
    n_dat = dac_dat;
    n_und = 1'b0;
    n_ucnt = underrun_cnt;
    pop = 1'b0;
    if (!enable) begin
      n_state = IDLE;
      n_dat = 1'b0;
    end else if (state == IDLE) begin
      n_state = WAIT_L;
      n_dat = 1'b0;
    end else begin
      if (lr_edge && !lr_new) begin
        pop = !empty;
        n_sh = empty ? '0 : rd[2*SAMPLE_W-1:SAMPLE_W];
        n_hold = empty ? '0 : rd[SAMPLE_W-1:0];
        n_und = empty;
        n_ucnt = underrun_cnt + 16'(empty && underrun_cnt != 16'hFFFF);
      end else if (lr_edge && state != WAIT_L) n_sh = hold_r;
      if (lr_edge && (!lr_new || state != WAIT_L)) begin
        n_cnt = CW'(SAMPLE_W);
        n_skip = SKIP0;
        n_state = SHIFT;
      end
      if (bfall && n_state == SHIFT) begin
        n_dat = n_skip ? 1'b0 : n_sh[SAMPLE_W-1];
        n_sh = n_skip ? n_sh : {n_sh[SAMPLE_W-2:0], 1'b0};
        n_cnt = n_skip ? n_cnt : n_cnt - 1'b1;
        n_state = n_cnt == '0 ? PAD : SHIFT;
        n_skip = 1'b0;
      end else if (bfall && n_state == PAD) n_dat = 1'b0;
    end
  end
  // sequencer state, shifter and counters
  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) begin
      state <= IDLE;
      sh <= '0;
      hold_r <= '0;
      cnt <= '0;
      skip <= 1'b0;
      dac_dat <= 1'b0;
      underrun <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      state <= n_state;
      sh <= n_sh;
      hold_r <= n_hold;
      cnt <= n_cnt;
      skip <= n_skip;
      dac_dat <= n_dat;
      underrun <= n_und;
      underrun_cnt <= n_ucnt;
    end
endmodule

// File: doc/audio_dac_scheduler.md
Name: audio_dac_scheduler

Overview:
- Sequences the audio DAC serial path. Accepts stereo sample frames from a processor-side source over a valid/ready handshake and buffers them in a small FIFO.
- Times each bit onto the DAC data line from the codec-driven bit clock and LR clock, pops one frame per left-channel start, and substitutes silence on underrun.
- Sits between the sample-producing datapath and the codec pins (BCLK in, DACLRCK in, DACDAT out).

Parameters:
- SAMPLE_W, 16, bits per channel sample.
- FIFO_DEPTH, 8, stereo frames buffered; power of two, ≥2.
- I2S_MODE, 1, 1 = I2S (MSB one BCLK after LRCK edge), 0 = left-justified (MSB at LRCK edge).

Ports:
- clk_clk  in  1  system clock; ≥4× BCLK frequency.
- reset_reset  in  1  reset, asynchronous, active-high. One clock domain (clk_clk). Reset asserts asynchronously, releases synchronously to clk_clk.
- enable  in  1  1 = play, 0 = output silence, no pops.
- s_data  in  2*SAMPLE_W  frame: [2*SAMPLE_W-1:SAMPLE_W] left, [SAMPLE_W-1:0] right, two's complement.
- s_valid  in  1  s_data valid.
- s_ready  out  1  FIFO can accept a frame.
- dac_bclk  in  1  codec bit clock, asynchronous to clk_clk.
- dac_lrck  in  1  codec LR clock; 0 = left, 1 = right.
- dac_dat  out  1  serial DAC data.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  frames held.
- underrun  out  1  one-cycle pulse on each frame replaced by silence.
- underrun_cnt  out  16  saturating underrun count.

Behaviour:
- Reset values:
  - Outputs: s_ready=1, dac_dat=0, fifo_level=0, underrun=0, underrun_cnt=0.
  - Internal: FIFO empty, state IDLE, shift register 0.
- Synchronizers:
  - dac_bclk and dac_lrck each pass through 2 flops, then a third flop for edge detection.
  - bfall = falling edge of synced BCLK.
  - lr_edge = any edge of synced LRCK; lr_left = lr_edge with new LRCK = 0.
- Handshake:
  - Push when s_valid && s_ready. s_ready = (level < FIFO_DEPTH).
  - Push and pop in the same cycle are both allowed; level is unchanged. When full, a pop that cycle does not raise s_ready until the next cycle.
- Timing: dac_dat is registered and updates in the cycle after bfall/lr_edge is detected, i.e. 3 clk_clk cycles after the raw pin edge.
- States:
  - IDLE: dac_dat=0. When enable=1, go to WAIT_L.
  - WAIT_L: dac_dat=0. On lr_left:
    - FIFO non-empty: pop the frame, latch the right half into hold_r, load the left half into the shift register.
    - FIFO empty: load 0 and hold_r=0, pulse underrun, increment underrun_cnt (saturate at 0xFFFF).
    - Then go to SHIFT with bitcnt=SAMPLE_W and skip=I2S_MODE.
  - SHIFT, each bfall:
    - skip=1: drive 0, clear skip.
    - skip=0: drive the shift register MSB, shift left, decrement bitcnt. When bitcnt reaches 0, go to PAD.
  - PAD: dac_dat=0 on each bfall.
  - lr_edge in SHIFT or PAD:
    - New LRCK=1: load hold_r, bitcnt=SAMPLE_W, skip=I2S_MODE, go to SHIFT.
    - New LRCK=0: perform the WAIT_L load/pop/underrun action.
  - An lr_edge arriving before bitcnt reaches 0 truncates the current word; the new word starts immediately.
- Simultaneous lr_edge and bfall in one cycle:
  - The load happens first, and the bfall is consumed by the new word.
  - LJ mode: MSB driven that cycle. I2S mode: this bfall is the skip slot.
  - I2S mode requires ≥ SAMPLE_W+1 BCLK per channel.
- enable:
  - enable=0 in any state: go to IDLE, dac_dat=0 immediately.
  - FIFO contents are retained and pushes are still accepted.
  - After re-enable, playback restarts only at the next lr_left. Frames are never split across an enable change.
- Underrun is counted only in WAIT_L/SHIFT/PAD, never in IDLE.
- Reset mid-word: dac_dat=0 at once, FIFO flushed, underrun_cnt cleared.

Decomposition:
- Package audio_dac_pkg:
  - SAMPLE_W default.
  - State enum {IDLE, WAIT_L, SHIFT, PAD}.
  - Frame typedef struct {left, right}.
- Sub-module audio_sample_fifo:
  - Synchronous FIFO, width 2*SAMPLE_W, depth FIFO_DEPTH.
  - Ports: push, pop, full, empty, level; fall-through read data.
- Top module contains the synchronizers, edge detection, FSM, shifter and counter.

Test Plan:
- Defaults, I2S, BCLK = clk/8, 32 BCLK per channel. Push frame L=0xA5C3, R=0x0F0F before the first lr_left.
  → The bfall coincident with the left LRCK edge drives 0; the next 16 bfalls drive 1010010111000011; the remaining slots drive 0.
  → The right channel serializes 0000111100001111; underrun_cnt=0.
- I2S_MODE=0, same stimulus → MSB 1 driven at the LRCK edge itself; no skip slot.
- FIFO empty across 3 left starts → dac_dat all 0, 3 underrun pulses, underrun_cnt=3. Push frame L=0x8001 → played on the next left start.
- Push 9 frames back-to-back with enable=0 → s_ready falls after the 8th, fifo_level=8, 9th stalls. Enable, first left start → level drops to 7, s_ready=1 next cycle, 9th accepted.
- Deassert enable mid-left-word → dac_dat=0 within 1 cycle. Re-enable mid-right-channel → output stays 0 until the next lr_left pops the next frame.
- Assert reset_reset asynchronously mid-SHIFT with 4 frames queued → dac_dat=0 and fifo_level=0 immediately, s_ready=1. After release: first left start reports underrun.
